instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
- Synthesizable instruction-memory responder: the memory end of the CPU's PC/INSTRUCTION fetch interface.
- Replaces the behavioural bench array and fixed #2 fetch delay with a clocked, multi-cycle read and a BUSYWAIT/VALID handshake.
- Holds a byte-addressed program store. A byte-wide load port lets the bench or a boot loader write the program before or during execution.

Parameters:
- DEPTH, 1024, number of bytes in the store; power of two.
- ADDR_W, 10, byte-address width; equals log2(DEPTH).
- READ_LATENCY, 2, clock edges from fetch acceptance to data valid; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  fetch request from the CPU.
- ADDRESS  input  32  fetch byte address (the PC). Only ADDRESS[ADDR_W-1:0] is used.
- BUSYWAIT  output  1  CPU must stall while this is high.
- INSTRUCTION  output  32  fetched word; holds its last value between fetches.
- VALID  output  1  one-cycle pulse: INSTRUCTION is new this cycle.
- LOAD_EN  input  1  byte write strobe.
- LOAD_ADDR  input  ADDR_W  byte write address.
- LOAD_DATA  input  8  byte write data.

Behaviour:
- Reset and clocking:
  - One clock, CLK. Reset RESET is synchronous and active-high.
  - On reset: state=IDLE, INSTRUCTION=32'h0, VALID=0, BUSYWAIT=0, latched address=0, counter=0.
  - Memory contents are not cleared by reset.
- Word assembly: INSTRUCTION = {mem[A], mem[A+1], mem[A+2], mem[A+3]}, big-endian from base A.
  - Every byte index is computed modulo DEPTH, so a base of DEPTH-2 wraps to bytes DEPTH-2, DEPTH-1, 0, 1.
  - There is no alignment requirement.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if READ=1 at an edge, latch ADDRESS, load counter with READ_LATENCY-1 and go to WAIT. Otherwise stay in IDLE.
  - WAIT: if counter != 0, decrement. If counter == 0, register the assembled word into INSTRUCTION and go to DONE.
  - DONE: VALID=1 for this single cycle. Next edge goes to IDLE unconditionally. A READ present in DONE is sampled only once back in IDLE, which gives one turnaround cycle.
- BUSYWAIT (combinational): BUSYWAIT = (state==IDLE && READ) || state==WAIT. It falls in the DONE cycle, together with VALID.
- Latency: the accepting edge is E0. INSTRUCTION and VALID update at edge E0+READ_LATENCY.
- ADDRESS changes during WAIT are ignored because the address was latched at acceptance.
- READ deasserted during WAIT: the fetch still completes and VALID still pulses.
- Load port: on an edge with LOAD_EN=1, mem[LOAD_ADDR] <= LOAD_DATA. Loads are accepted in any state.
- Load during WAIT: the completing fetch sees all writes from earlier edges. A write on the completion edge itself is not seen (old byte returned).
- RESET during WAIT or DONE aborts the fetch: no VALID pulse, outputs return to reset values. A load on the same edge as RESET is still performed.

Optional Feature:
- Macro: INSTR_BUF_EN.
- Defined: adds a one-entry word buffer (tag = latched base address, data word, valid bit).
  - IDLE with READ=1 and a matching valid tag: BUSYWAIT stays 0. Next edge loads INSTRUCTION from the buffer and goes directly to DONE (1-edge latency).
  - Every completed memory fetch refills the buffer.
  - The buffer is invalidated by RESET and by any LOAD_EN write to any of the 4 bytes covered by the tag (wrap-aware).
- Undefined: no buffer; every fetch takes READ_LATENCY edges.

Decomposition:
- Shared package instr_mem_pkg holds:
  - the state enum {IDLE, WAIT, DONE};
  - the default DEPTH / ADDR_W / READ_LATENCY constants;
  - the INSTR_W=32 constant;
  - the RESET_INSTR=32'h0 constant.
- Sub-module instr_byte_ram holds the byte array, with four asynchronous read ports (A..A+3 modulo DEPTH) and one synchronous write port. The FSM, counter and optional buffer stay in the top.

Test Plan:
- Basic fetch: bytes 0..3 loaded with 8'h00, 8'h04, 8'h00, 8'h05; READ=1, ADDRESS=0, READ_LATENCY=2 -> BUSYWAIT high for 2 cycles; INSTRUCTION=32'h00040005 and VALID pulses exactly once at E0+2.
- Wrap-around: DEPTH=1024, bytes 1022, 1023, 0, 1 = AA, BB, CC, DD; fetch ADDRESS=1022 -> INSTRUCTION=32'hAABBCCDD.
- Address change mid-wait: fetch ADDRESS=4, then change ADDRESS to 8 during WAIT -> word from base 4 is returned.
- Reset mid-fetch: RESET pulsed for one cycle during WAIT -> no VALID pulse; INSTRUCTION=0, BUSYWAIT=0 next cycle; memory bytes still intact on a re-fetch.
- Load collision: write byte 5 = 8'h77 one edge before completion of a fetch at 4 -> returned word byte 1 = 77. Write on the completion edge -> old byte returned.
- INSTR_BUF_EN: fetch 0 twice -> second fetch has BUSYWAIT=0 and 1-edge latency. Then load byte 2 and fetch 0 again -> full READ_LATENCY with the updated data.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and default constants for the instruction-memory responder.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH        = 1024;
    localparam int DEFAULT_ADDR_W       = 10;
    localparam int DEFAULT_READ_LATENCY = 2;

    localparam int                 INSTR_W     = 32;
    localparam logic [INSTR_W-1:0] RESET_INSTR = 32'h0;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-addressed program store: one synchronous byte write port and four
// asynchronous read ports at A..A+3, wrapping modulo DEPTH.
module instr_byte_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata0,
    output logic [7:0]        rdata1,
    output logic [7:0]        rdata2,
    output logic [7:0]        rdata3
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // DEPTH is a power of two, so ADDR_W-bit addition wraps for free.
    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr + ADDR_W'(1)];
    assign rdata2 = mem[raddr + ADDR_W'(2)];
    assign rdata3 = mem[raddr + ADDR_W'(3)];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory end of the CPU fetch interface: multi-cycle big-endian word read with
// BUSYWAIT/VALID handshake. Define INSTR_BUF_EN to add a one-entry word buffer.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic [31:0]        ADDRESS,
    output logic               BUSYWAIT,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic               VALID,
    input  logic               LOAD_EN,
    input  logic [ADDR_W-1:0]  LOAD_ADDR,
    input  logic [7:0]         LOAD_DATA
);

    localparam int CNT_W = 4;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [ADDR_W-1:0]  addr_q, addr_next;
    logic [INSTR_W-1:0] instr_q, instr_next;
    logic [INSTR_W-1:0] mem_word;
    logic [7:0]         rd0, rd1, rd2, rd3;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               unused_addr_hi;
    logic               buf_hit;
    logic [INSTR_W-1:0] buf_word;

    assign fetch_addr     = ADDRESS[ADDR_W-1:0];
    assign unused_addr_hi = ^ADDRESS[31:ADDR_W];

    instr_byte_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (CLK),
        .we     (LOAD_EN),
        .waddr  (LOAD_ADDR),
        .wdata  (LOAD_DATA),
        .raddr  (addr_q),
        .rdata0 (rd0),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .rdata3 (rd3)
    );

    assign mem_word = {rd0, rd1, rd2, rd3};

`ifdef INSTR_BUF_EN
    logic [ADDR_W-1:0]  buf_tag, buf_tag_next;
    logic [INSTR_W-1:0] buf_data, buf_data_next;
    logic               buf_vld, buf_vld_next;

    // True when byte address wa falls in the four bytes starting at base.
    function automatic logic covers(input logic [ADDR_W-1:0] wa,
                                    input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] dist;
        dist = wa - base;
        return dist < ADDR_W'(4);
    endfunction

    assign buf_hit  = buf_vld && (buf_tag == fetch_addr);
    assign buf_word = buf_data;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = RESET_INSTR;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr_q;
        instr_next = instr_q;
`ifdef INSTR_BUF_EN
        buf_tag_next  = buf_tag;
        buf_data_next = buf_data;
        buf_vld_next  = buf_vld;
`endif
        case (state)
            IDLE: begin
                if (READ) begin
                    addr_next = fetch_addr;
                    if (buf_hit) begin
                        instr_next = buf_word;
                        state_next = DONE;
                    end else begin
                        cnt_next   = CNT_W'(READ_LATENCY - 1);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    instr_next = mem_word;
                    state_next = DONE;
`ifdef INSTR_BUF_EN
                    buf_tag_next  = addr_q;
                    buf_data_next = mem_word;
                    buf_vld_next  = 1'b1;
`endif
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef INSTR_BUF_EN
        // A write on the refill edge is not in the captured word, so the
        // check runs against the tag the buffer will hold after this edge.
        if (LOAD_EN && covers(LOAD_ADDR, buf_tag_next)) begin
            buf_vld_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            instr_q <= RESET_INSTR;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            addr_q  <= addr_next;
            instr_q <= instr_next;
        end
    end

`ifdef INSTR_BUF_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_vld <= 1'b0;
        end else begin
            buf_vld <= buf_vld_next;
        end
        buf_tag  <= buf_tag_next;
        buf_data <= buf_data_next;
    end
`endif

    assign BUSYWAIT    = (state == IDLE && READ && !buf_hit) || (state == WAIT);
    assign VALID       = (state == DONE);
    assign INSTRUCTION = instr_q;

endmodule
